// File: rtl/uart_ctrl_pkg.sv
// Shared state encoding and constants for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int BYTE_W    = 8;
  localparam int N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Bits needed for a counter holding 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr+1.
module uart_rr_picker
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  // Candidates visited in priority order; the last owner (ptr itself) comes last.
  always_comb begin
    win  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!any && req[j] && (cand == PTR_W'(j))) begin
          win[j] = 1'b1;
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin sharing of one UART transmitter among N_REQ byte streams,
// paced by the transmitter's busy flag, with an idle-timeout on stalled owners.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                    CLOCK_50,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        timeout_err,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    arb_busy
);

  localparam int               PTR_W   = $clog2(N_REQ);
  localparam int               CNT_W   = cnt_width(IDLE_TIMEOUT);
  localparam bit               TO_EN   = (IDLE_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = TO_EN ? CNT_W'(IDLE_TIMEOUT - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic [N_REQ-1:0]   timeout_err_q, timeout_err_d;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               arb_busy_q, arb_busy_d;

  logic [N_REQ-1:0]   pick_win;
  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;
  logic               own_valid;
  logic               own_last;
  logic [BYTE_W-1:0]  own_byte;

  uart_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_win[j]) pick_idx = PTR_W'(j);
    end
  end

  // Only the current owner's slice is ever looked at while a grant is held.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_byte  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (owner_q == PTR_W'(j)) begin
        own_valid = req_valid[j];
        own_last  = req_last[j];
        own_byte  = req_data[j*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    req_ready_d   = '0;
    timeout_err_d = '0;
    tx_start_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        // An offered byte wins over an expiring timeout in the same cycle.
        if (own_valid && !tx_busy) begin
          tx_data_d   = own_byte;
          last_d      = own_last;
          tx_start_d  = 1'b1;
          req_ready_d = grant_q;
          state_d     = WAIT_ACK;
        end else if (TO_EN && (cnt_q == CNT_LIM)) begin
          timeout_err_d = grant_q;
          grant_d       = '0;
          rr_ptr_d      = owner_q;
          state_d       = IDLE;
        end else if (!own_valid && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = owner_q;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = SEND;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= PTR_W'(N_REQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      grant_q       <= '0;
      req_ready_q   <= '0;
      timeout_err_q <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      arb_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      req_ready_q   <= req_ready_d;
      timeout_err_q <= timeout_err_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      arb_busy_q    <= arb_busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign arb_busy    = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic against a packet-order model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           CLOCK_50;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [N-1:0]   timeout_err;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           arb_busy;

  int checks    = 0;
  int errors    = 0;
  int frame_len = 10;
  int busy_cnt  = 0;

  typedef struct {
    int         r;
    logic [7:0] d;
  } ev_t;

  logic [7:0] rq_data [N][$];
  logic       rq_last [N][$];
  int         rq_pos  [N];
  int         rq_gap  [N];
  ev_t        exp_q   [$];

  uart_tx_arbiter #(
    .N_REQ        (N),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .timeout_err (timeout_err),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .arb_busy    (arb_busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Transmitter stand-in: busy for frame_len cycles starting the cycle after tx_start.
  always @(posedge CLOCK_50 or negedge rst) begin
    if (!rst)                busy_cnt <= 0;
    else if (tx_start)       busy_cnt <= frame_len;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    req_valid[r]       = v;
    req_data[r*8 +: 8] = d;
    req_last[r]        = l;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_busy_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!tx_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    clear_inputs();
    rst = 1'b1;
    #5 rst = 1'b0;
    #3;
    checks++;
    if ({grant, req_ready, timeout_err, tx_start, tx_data, arb_busy} !== 22'h0) begin
      errors++;
      $display("FAIL reset_async: got %h required 0", {grant, req_ready, timeout_err, tx_start, tx_data, arb_busy});
    end
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (grant !== 4'b0000 || arb_busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: grant %b arb_busy %b tx_start %b required 0000 0 0", grant, arb_busy, tx_start);
    end
    wait_idle(ok);
  endtask

  task automatic test_single_byte();
    bit ok;
    do_reset();
    frame_len = 10;
    set_req(1, 1'b1, 8'hA5, 1'b1);
    tick();
    checks++;
    if (grant !== 4'b0010 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant %b tx_start %b required 0010 0", grant, tx_start);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_start: tx_start %b tx_data %h required 1 a5", tx_start, tx_data);
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready: got %b required 0010", req_ready);
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (req_ready !== 4'b0000 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: req_ready %b tx_start %b required 0000 0", req_ready, tx_start);
    end
    wait_busy_fall(ok);
    checks++;
    if (!ok || grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_hold: ok %0d grant %b required 1 0010", ok, grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant %b arb_busy %b required 0000 0", grant, arb_busy);
    end
  endtask

  task automatic test_packet_ownership();
    logic [7:0] pkt [3];
    logic [7:0] got [$];
    int n0;
    bit early, reached, seen2, ok;
    pkt = '{8'h48, 8'h49, 8'h0A};
    do_reset();
    frame_len = 6;
    n0 = 0; early = 1'b0; reached = 1'b0; seen2 = 1'b0;
    set_req(0, 1'b1, pkt[0], 1'b0);
    set_req(2, 1'b1, 8'h77, 1'b1);
    for (int cyc = 0; cyc < 400 && !reached; cyc++) begin
      tick();
      if (tx_start === 1'b1) begin
        got.push_back(tx_data);
        checks++;
        if (req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL own_ready: got %b required 0001", req_ready);
        end
      end
      if (grant[2] && (got.size() < 3 || tx_busy)) early = 1'b1;
      if (grant === 4'b0100) reached = 1'b1;
      if (req_ready[0]) begin
        n0++;
        if (n0 < 3) set_req(0, 1'b1, pkt[n0], n0 == 2);
        else        set_req(0, 1'b0, 8'h00, 1'b0);
      end
    end
    checks++;
    if (got.size() != 3 || early || !reached) begin
      errors++;
      $display("FAIL own_sequence: starts %0d early %0d reached %0d required 3 0 1", got.size(), early, reached);
    end
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== pkt[i]) begin
          errors++;
          $display("FAIL own_byte%0d: got %h required %h", i, got[i], pkt[i]);
        end
      end
    end
    for (int cyc = 0; cyc < 50 && !seen2; cyc++) begin
      tick();
      if (tx_start === 1'b1) begin
        seen2 = 1'b1;
        set_req(2, 1'b0, 8'h00, 1'b0);
        checks++;
        if (tx_data !== 8'h77 || req_ready !== 4'b0100) begin
          errors++;
          $display("FAIL own_next: data %h ready %b required 77 0100", tx_data, req_ready);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (!seen2 || !ok) begin
      errors++;
      $display("FAIL own_drain: seen %0d idle %0d required 1 1", seen2, ok);
    end
  endtask

  task automatic test_round_robin();
    int exp_r [5];
    logic [7:0] exp_d [5];
    int n;
    bit ok;
    exp_r = '{0, 1, 2, 3, 0};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    do_reset();
    frame_len = 4;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(16 + i), 1'b1);
    n = 0;
    for (int cyc = 0; cyc < 400 && n < 5; cyc++) begin
      tick();
      checks++;
      if ($countones(req_ready) > 1 || tx_start !== (req_ready != 4'b0000)) begin
        errors++;
        $display("FAIL rr_one_ready: req_ready %b tx_start %b", req_ready, tx_start);
      end
      if (tx_start === 1'b1) begin
        checks++;
        if (req_ready !== 4'(1 << exp_r[n]) || tx_data !== exp_d[n]) begin
          errors++;
          $display("FAIL rr_order%0d: ready %b data %h required %b %h", n, req_ready, tx_data, 4'(1 << exp_r[n]), exp_d[n]);
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) set_req(i, 1'b1, 8'(32 + i), 1'b1);
        n++;
      end
    end
    clear_inputs();
    wait_idle(ok);
    checks++;
    if (n != 5 || !ok) begin
      errors++;
      $display("FAIL rr_count: starts %0d idle %0d required 5 1", n, ok);
    end
  endtask

  task automatic test_timeout();
    bit ok, early;
    do_reset();
    frame_len = 5;
    set_req(3, 1'b1, 8'h11, 1'b0);
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL to_grant: got %b required 1000", grant);
    end
    set_req(0, 1'b1, 8'h22, 1'b1);
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h11 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL to_start: start %b data %h ready %b required 1 11 1000", tx_start, tx_data, req_ready);
    end
    set_req(3, 1'b0, 8'h00, 1'b0);
    tick();
    wait_busy_fall(ok);
    early = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (timeout_err !== 4'b0000 || grant !== 4'b1000) early = 1'b1;
    end
    checks++;
    if (!ok || early) begin
      errors++;
      $display("FAIL to_early: busy_fell %0d early %0d required 1 0", ok, early);
    end
    tick();
    checks++;
    if (timeout_err !== 4'b1000) begin
      errors++;
      $display("FAIL to_pulse: got %b required 1000", timeout_err);
    end
    checks++;
    if (grant !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_release: grant %b arb_busy %b required 0000 0", grant, arb_busy);
    end
    tick();
    checks++;
    if (timeout_err !== 4'b0000 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL to_next_owner: timeout_err %b grant %b required 0000 0001", timeout_err, grant);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h22 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL to_next_byte: start %b data %h ready %b required 1 22 0001", tx_start, tx_data, req_ready);
    end
    clear_inputs();
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    frame_len = 10;
    set_req(1, 1'b1, 8'h5A, 1'b1);
    tick();
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checks++;
    if (tx_busy !== 1'b1 || arb_busy !== 1'b1 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL rst_setup: busy %b arb_busy %b grant %b required 1 1 0010", tx_busy, arb_busy, grant);
    end
    #5 rst = 1'b0;
    #1;
    checks++;
    if ({grant, req_ready, timeout_err, tx_start, tx_data, arb_busy} !== 22'h0) begin
      errors++;
      $display("FAIL rst_async_clear: got %h required 0", {grant, req_ready, timeout_err, tx_start, tx_data, arb_busy});
    end
    tick();
    rst = 1'b1;
    set_req(2, 1'b1, 8'h3C, 1'b1);
    tick();
    checks++;
    if (grant !== 4'b0100 || req_ready !== 4'b0000 || timeout_err !== 4'b0000) begin
      errors++;
      $display("FAIL rst_regrant: grant %b ready %b timeout %b required 0100 0000 0000", grant, req_ready, timeout_err);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h3C || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rst_restart: start %b data %h ready %b required 1 3c 0100", tx_start, tx_data, req_ready);
    end
    clear_inputs();
    wait_idle(ok);
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (rq_pos[i] < rq_data[i].size() && rq_gap[i] == 0)
        set_req(i, 1'b1, rq_data[i][rq_pos[i]], rq_last[i][rq_pos[i]]);
      else
        set_req(i, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_random_traffic();
    int mptr, found, r, npk, len, exp_idx, cyc;
    int mpos [N];
    bit done, last_seen;
    ev_t ev;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
      rq_pos[i] = 0;
      rq_gap[i] = 0;
      mpos[i]   = 0;
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          rq_data[i].push_back(8'($urandom));
          rq_last[i].push_back(b == len - 1);
        end
      end
    end
    // Whole packets in round-robin order over requesters that still hold data.
    mptr = N - 1;
    done = 1'b0;
    while (!done) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        r = (mptr + k) % N;
        if (found < 0 && mpos[r] < rq_data[r].size()) found = r;
      end
      if (found < 0) begin
        done = 1'b1;
      end else begin
        last_seen = 1'b0;
        while (!last_seen) begin
          ev.r = found;
          ev.d = rq_data[found][mpos[found]];
          last_seen = rq_last[found][mpos[found]];
          exp_q.push_back(ev);
          mpos[found]++;
        end
        mptr = found;
      end
    end
    exp_idx = 0;
    drive_random();
    for (cyc = 0; cyc < 20000 && !(exp_idx >= exp_q.size() && !arb_busy); cyc++) begin
      frame_len = $urandom_range(2, 8);
      tick();
      checks++;
      if ($countones(req_ready) > 1 || tx_start !== (req_ready != 4'b0000) ||
          timeout_err !== 4'b0000 || (req_ready & ~grant) !== 4'b0000) begin
        errors++;
        $display("FAIL rand_protocol: ready %b start %b timeout %b grant %b", req_ready, tx_start, timeout_err, grant);
      end
      if (tx_start === 1'b1) begin
        checks++;
        if (exp_idx >= exp_q.size()) begin
          errors++;
          $display("FAIL rand_extra_start: data %h ready %b required no start", tx_data, req_ready);
        end else if (tx_data !== exp_q[exp_idx].d || req_ready !== 4'(1 << exp_q[exp_idx].r)) begin
          errors++;
          $display("FAIL rand_byte%0d: data %h ready %b required %h %b", exp_idx, tx_data, req_ready,
                   exp_q[exp_idx].d, 4'(1 << exp_q[exp_idx].r));
        end
        exp_idx++;
      end
      for (int i = 0; i < N; i++) if (rq_gap[i] > 0) rq_gap[i]--;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          rq_pos[i]++;
          rq_gap[i] = $urandom_range(0, 4);
        end
      end
      drive_random();
    end
    checks++;
    if (exp_idx != exp_q.size() || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: bytes %0d arb_busy %b required %0d 0", exp_idx, arb_busy, exp_q.size());
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_packet_ownership();
    test_round_robin();
    test_timeout();
    test_reset_mid_frame();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single async UART transmitter between `N_REQ` byte-stream requesters. It grants one requester at a time for a whole packet, which is a run of bytes ending in a byte flagged `last`. It drives the transmitter's start/data inputs and paces bytes off its busy indication. An idle-timeout releases a granted requester that stalls mid-packet. It sits between the on-board byte producers (switch logger, status reporter, debug dump) and the transmitter instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `IDLE_TIMEOUT`, 1024: cycles a granted requester may leave `req_valid` low mid-packet before forced release. 0 disables the timeout.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  N_REQ  requester i has a byte on its data slice.
- `req_data`  in  8*N_REQ  requester i byte at bits [8i+7:8i].
- `req_last`  in  N_REQ  byte from requester i ends its packet.
- `req_ready`  out  N_REQ  one-cycle pulse: requester i's byte was accepted. The requester advances its data on this pulse.
- `grant`  out  N_REQ  one-hot current owner. All zero when idle.
- `timeout_err`  out  N_REQ  one-cycle pulse on forced release of requester i.
- `tx_start`  out  1  start pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter. Valid while `tx_start` is high.
- `tx_busy`  in  1  transmitter busy (not ready). High from the cycle after start until the stop bit ends.
- `arb_busy`  out  1  high whenever state != IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset state is IDLE, `rr_ptr` = N_REQ-1, timeout counter = 0.
- IDLE
  - If any `req_valid` is high, pick the first set bit searching from `rr_ptr`+1 upward, wrapping modulo N_REQ.
  - Set `grant` one-hot to the winner and go to SEND.
  - Clear the timeout counter.
- SEND, owner g
  - If `req_valid[g]` and !`tx_busy`: register `tx_data` = byte g and `last_q` = `req_last[g]`. Pulse `tx_start` and `req_ready[g]` next cycle. Go to WAIT_ACK.
  - Else, if `req_valid[g]` is low, increment the counter.
  - When the counter reaches IDLE_TIMEOUT-1 (timeout enabled): pulse `timeout_err[g]`, clear `grant`, set `rr_ptr` = g, go to IDLE.
  - Other requesters' `req_valid` are ignored while a grant is held.
- WAIT_ACK: wait for `tx_busy` = 1, then go to WAIT_DONE.
- WAIT_DONE
  - On `tx_busy` = 0 with `last_q`: clear `grant`, set `rr_ptr` = g, go to IDLE.
  - On `tx_busy` = 0 without `last_q`: clear the counter and go to SEND.
- Only one `req_ready` bit and at most one `tx_start` can be high in any cycle. Exactly one `tx_start` is issued per accepted byte.
- Simultaneous requests in IDLE: round-robin order only. The last owner has lowest priority next time.
- `req_valid[g]` dropping while in WAIT_ACK or WAIT_DONE has no effect.
- Counter width is clog2(IDLE_TIMEOUT+1) and saturates. It never wraps.
- Reset asserted mid-packet: immediate return to reset values. No `req_ready` or `timeout_err` pulse is generated. The transmitter shares `rst` and aborts too.

## Timing
- Request to start
  - Cycle 0: IDLE sees `req_valid[i]`.
  - Cycle 1: `grant[i]` = 1, SEND samples the byte.
  - Cycle 2: `tx_start` = 1, `tx_data` valid, `req_ready[i]` = 1.
  - Cycle 3: `tx_busy` rises. The state becomes WAIT_DONE at cycle 4.
- Back-to-back bytes in a packet
  - Next `tx_start` occurs 2 cycles after `tx_busy` falls (WAIT_DONE→SEND, SEND→start).
  - Byte gap is therefore 2 clocks plus the transmitter's frame time of 10 baud ticks.
- Packet end
  - `grant` is clear 1 cycle after `tx_busy` falls.
  - A new grant comes 1 cycle later, in the earliest case.
- Timeout
  - `timeout_err` pulses IDLE_TIMEOUT cycles after SEND is entered with `req_valid[g]` low.

## Structure
- Shared package `uart_ctrl_pkg` holds:
  - the state enum IDLE/SEND/WAIT_ACK/WAIT_DONE;
  - the default N_REQ;
  - the byte width constant 8.
- Sub-module `uart_rr_picker` is combinational. Inputs are a `req` vector and `ptr`. Outputs are a one-hot `win` and a `any` flag.
- The FSM, counter and output registers stay in `uart_tx_arbiter`.

## Test plan
- Single byte: requester 1 sends 0xA5 with last=1 → `grant` = 0010 at cycle 1; `tx_start` with 0xA5 and `req_ready[1]` at cycle 2; `grant` = 0 one cycle after `tx_busy` falls.
- Packet ownership: requester 0 streams 0x48,0x49,0x0A (last on 0x0A) while requester 2 holds `req_valid` → three starts in that order, no grant to 2 until the packet ends, then `grant` = 0100.
- Round-robin: all four requesters hold 1-byte packets from reset → grant order 0,1,2,3,0. Exactly one `req_ready` per packet.
- Timeout with IDLE_TIMEOUT=16: requester 3 sends 0x11 without last, then drops `req_valid` → `timeout_err[3]` pulses 16 cycles after re-entering SEND, `grant` clears, and requester 0 is served next.
- Reset mid-frame: assert `rst` low during WAIT_DONE → all outputs 0 asynchronously. After release, a new request on requester 2 is granted with cycle-1 latency.
